// File: rtl/core_config_pkg.sv
// Shared core configuration: datapath width, reset vector, fetch buffer
// entry layout and the fetch sequencer state encoding.
package core_config_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000;
    localparam logic [XLEN-1:0] PC_STEP      = 32'h0000_0004;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry ordered buffer of fetched instructions. Push and pop in the same
// cycle are legal at any occupancy; flush empties the buffer and wins over push.
module fetch_fifo
    import core_config_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Qualify requests: never pop an empty buffer, never push into a full one
    // unless the head leaves in the same cycle (its slot is then reused).
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head is read straight from storage so it stays put while not popped.
    always_comb begin
        head = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, one outstanding ROM read with a
// fixed one-cycle response, a two-entry instruction buffer toward decode, and
// redirects from the branch predictor and the execute stage.
module fetch_unit
    import core_config_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bpu_pc_write,
    input  logic [XLEN-1:0] bpu_pc_value,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    output logic            rom_req,
    output logic [XLEN-1:0] rom_addr,
    input  logic [31:0]     rom_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc
);

    fetch_state_t    state_q;
    fetch_state_t    state;
    fetch_state_t    state_next;

    logic [XLEN-1:0] pc_q;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            pop;
    logic            push;
    logic [2:0]      occupancy;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Redirect source selection; the execute stage outranks the predictor.
    always_comb begin
        redirect        = ex_redirect || bpu_pc_write;
        redirect_target = ex_redirect ? ex_target : bpu_pc_value;
    end

    // Decode handshake and projected buffer occupancy at the end of this cycle.
    always_comb begin
        instr_valid = (count != 2'd0);
        pop         = instr_valid && instr_ready;
        occupancy   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    end

    // Sequencer state register; only BOOT or RUN is ever stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state and request generation. REDIR is the cycle the strobe is seen,
    // so it is decoded from the strobe itself rather than from the register;
    // that lets the target be requested in the very next cycle.
    always_comb begin
        state      = redirect ? ST_REDIR : state_q;
        state_next = state;
        rom_req    = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                state_next = ST_RUN;
                rom_req    = (occupancy < 3'd2);
            end
            ST_REDIR: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Program counter: load the aligned target on redirect, else step per request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (redirect) begin
            pc_q <= align_pc(redirect_target);
        end else if (rom_req) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // In-flight tracking; a redirect issues no request, which drops the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= rom_req;
            if (rom_req) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // Response capture into the buffer; a redirect discards it.
    always_comb begin
        push             = inflight_q && !redirect;
        push_entry.pc    = inflight_pc_q;
        push_entry.instr = rom_data;
        rom_addr         = pc_q;
        instr_data       = head.instr;
        instr_pc         = head.pc;
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model checked
// every cycle, directed literal checks, and a randomized phase with redirects,
// decode back-pressure and mid-stream resets.
module tb_fetch_unit;
    import core_config_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bpu_pc_write;
    logic [31:0] bpu_pc_value;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bpu_pc_write (bpu_pc_write),
        .bpu_pc_value (bpu_pc_value),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc)
    );

    // ROM contents: a scrambled function of the word address.
    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ROM: answers the previous cycle's request, garbage otherwise.
    logic        req_s  = 1'b0;
    logic [31:0] addr_s = '0;
    always @(negedge clk) begin
        req_s  = rom_req;
        addr_s = rom_addr;
    end
    always @(posedge clk) begin
        #1;
        rom_data = req_s ? rom_f(addr_s) : $urandom();
    end

    // Reference model: expected buffer contents, pending response, fetch PC.
    fetch_entry_t mq[$];
    bit           pend    = 1'b0;
    logic [31:0]  pend_pc = '0;
    logic [31:0]  mpc     = RESET_VECTOR;
    bit           mboot   = 1'b1;

    always @(negedge clk) begin : model_cmp
        bit   exp_valid;
        bit   exp_req;
        bit   mpop;
        bit   redir;
        int   occ;
        fetch_entry_t e;
        if (!rst_n) begin
            chk("rst_rom_req", rom_req, 0);
            chk("rst_rom_addr", rom_addr, RESET_VECTOR);
            chk("rst_instr_valid", instr_valid, 0);
            mq.delete();
            pend  = 1'b0;
            mpc   = RESET_VECTOR;
            mboot = 1'b1;
        end else begin
            exp_valid = (mq.size() > 0);
            mpop      = exp_valid && instr_ready;
            redir     = ex_redirect || bpu_pc_write;
            occ       = mq.size() + int'(pend) - int'(mpop);
            exp_req   = !mboot && !redir && (occ < 2);
            chk("rom_req", rom_req, exp_req);
            if (exp_req) chk("rom_addr", rom_addr, mpc);
            chk("instr_valid", instr_valid, exp_valid);
            if (exp_valid) begin
                chk("instr_pc", instr_pc, mq[0].pc);
                chk("instr_data", instr_data, mq[0].instr);
            end
            mboot = 1'b0;
            if (redir) begin
                mq.delete();
                pend = 1'b0;
                mpc  = ex_redirect ? {ex_target[31:2], 2'b00} : {bpu_pc_value[31:2], 2'b00};
            end else begin
                if (mpop) void'(mq.pop_front());
                if (pend) begin
                    e.pc    = pend_pc;
                    e.instr = rom_f(pend_pc);
                    mq.push_back(e);
                end
                pend    = exp_req;
                pend_pc = mpc;
                if (exp_req) mpc = mpc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bpu_pc_write = 1'b0;
        ex_redirect  = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rom_req", rom_req, 0);
        chk("async_rom_addr", rom_addr, RESET_VECTOR);
        chk("async_instr_valid", instr_valid, 0);
        chk("async_instr_data", instr_data, 0);
        chk("async_instr_pc", instr_pc, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        rst_n        = 1'b0;
        bpu_pc_write = 1'b0;
        bpu_pc_value = '0;
        ex_redirect  = 1'b0;
        ex_target    = '0;
        instr_ready  = 1'b0;
        repeat (3) tick();
        chk("reset_instr_data", instr_data, 0);
        chk("reset_instr_pc", instr_pc, 0);
        instr_ready = 1'b1;
        rst_n       = 1'b1;

        // Boot sequence timing, with cycle 0 being the first cycle out of reset.
        for (int c = 0; c < 6; c++) begin
            sample();
            case (c)
                0: chk("boot_no_req", rom_req, 0);
                1: begin
                    chk("first_req", rom_req, 1);
                    chk("first_addr", rom_addr, RESET_VECTOR);
                end
                2: chk("valid_not_yet", instr_valid, 0);
                3: begin
                    chk("first_valid", instr_valid, 1);
                    chk("first_pc", instr_pc, RESET_VECTOR);
                    chk("first_data", instr_data, rom_f(RESET_VECTOR));
                end
                4: chk("second_pc", instr_pc, RESET_VECTOR + 32'd4);
                default: chk("third_pc", instr_pc, RESET_VECTOR + 32'd8);
            endcase
        end

        // Back-pressure: head frozen on the fourth fetched instruction.
        tick();
        instr_ready = 1'b0;
        repeat (10) tick();
        sample();
        chk("stall_valid", instr_valid, 1);
        chk("stall_pc", instr_pc, RESET_VECTOR + 32'd12);
        chk("stall_no_req", rom_req, 0);
        tick();
        instr_ready = 1'b1;
        repeat (6) tick();

        // Predictor redirect with unaligned target.
        bpu_pc_write = 1'b1;
        bpu_pc_value = 32'h0000_0103;
        sample();
        chk("redir_cycle_no_req", rom_req, 0);
        tick();
        clear_strobes();
        sample();
        chk("redir_req", rom_req, 1);
        chk("redir_addr", rom_addr, 32'h0000_0100);
        chk("redir_flushed", instr_valid, 0);
        tick();
        tick();
        sample();
        chk("redir_valid", instr_valid, 1);
        chk("redir_pc", instr_pc, 32'h0000_0100);

        // Execute redirect beats predictor redirect.
        tick();
        ex_redirect  = 1'b1;
        ex_target    = 32'h0000_0200;
        bpu_pc_write = 1'b1;
        bpu_pc_value = 32'h0000_0300;
        tick();
        clear_strobes();
        sample();
        chk("prio_addr", rom_addr, 32'h0000_0200);
        tick();
        sample();
        chk("prio_next_addr", rom_addr, 32'h0000_0204);

        // PC wrap at the top of the address space.
        tick();
        bpu_pc_write = 1'b1;
        bpu_pc_value = 32'hFFFF_FFFC;
        tick();
        clear_strobes();
        sample();
        chk("wrap_addr_top", rom_addr, 32'hFFFF_FFFC);
        tick();
        sample();
        chk("wrap_req", rom_req, 1);
        chk("wrap_addr_zero", rom_addr, 32'h0000_0000);
        tick();
        sample();
        chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
        tick();
        sample();
        chk("wrap_pc_zero", instr_pc, 32'h0000_0000);

        mid_reset();

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            tick();
            r            = $urandom_range(0, 99);
            instr_ready  = ($urandom_range(0, 9) < 7);
            ex_redirect  = (r < 4);
            bpu_pc_write = (r >= 2) && (r < 8);
            ex_target    = $urandom();
            bpu_pc_value = $urandom();
            if (r == 99) begin
                clear_strobes();
                mid_reset();
            end
        end
        clear_strobes();
        instr_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 bpu_pc_write  input  1  branch-predictor redirect strobe.
REQ-004 bpu_pc_value  input  XLEN  predicted target, used when bpu_pc_write=1.
REQ-005 ex_redirect  input  1  execute-stage mispredict redirect strobe.
REQ-006 ex_target  input  XLEN  resolved target, used when ex_redirect=1.
REQ-007 rom_req  output  1  instruction ROM read request.
REQ-008 rom_addr  output  XLEN  ROM byte address; bits [1:0] always 0.
REQ-009 rom_data  input  32  ROM read data, valid exactly one cycle after the rom_req cycle.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 instr_ready  input  1  decode accepts the head; pop when instr_valid && instr_ready.
REQ-012 instr_data  output  32  head instruction word.
REQ-013 instr_pc  output  XLEN  head instruction address.

Function
REQ-014 The block SHALL keep a PC register, a 2-entry FIFO of {pc, instr}, and one in-flight flag with its tagged pc.
REQ-015 FSM states SHALL be BOOT (first cycle after reset, no request), RUN, and REDIR (the cycle a redirect is taken; no request); BOOT->RUN and REDIR->RUN unconditionally; any state->REDIR on redirect.
REQ-016 In RUN, rom_req SHALL be 1 iff (fifo_count + inflight - pop) < 2; on request, rom_addr = PC and PC <= PC + 4 (mod 2^XLEN, wrap silent).
REQ-017 The response SHALL be enqueued at the end of the cycle following the request, with the tagged pc; instr_valid SHALL rise the next cycle (request-to-valid latency 2 cycles).
REQ-018 Simultaneous enqueue and pop on a full or one-entry FIFO SHALL be legal and preserve order; no entry SHALL be overwritten or dropped without a redirect.
REQ-019 A redirect (ex_redirect or bpu_pc_write) SHALL set PC <= target with bits [1:0] cleared, empty the FIFO, discard any in-flight response, and force instr_valid=0 the following cycle.
REQ-020 If ex_redirect and bpu_pc_write are both 1, ex_target SHALL win.
REQ-021 A redirect in the same cycle as a pop SHALL still complete the pop handshake; the popped entry is considered delivered.
REQ-022 Redirect at cycle N SHALL yield rom_req for the target at N+1 and instr_valid with instr_pc=target at N+3.
REQ-023 With instr_ready held 1 and no redirects, steady-state throughput SHALL be one instruction per cycle.
REQ-024 instr_data/instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.

Reset
REQ-025 On rst_n=0: PC=RESET_VECTOR, FIFO empty, in-flight cleared, state=BOOT, rom_req=0, rom_addr=RESET_VECTOR, instr_valid=0, instr_data=0, instr_pc=0.
REQ-026 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight response immediately; no response SHALL be enqueued after release.

Structure
REQ-027 RESET_VECTOR and typedef fetch_entry_t {pc XLEN, instr 32} SHALL live in core_config_pkg; XLEN taken from it.
REQ-028 The FIFO SHALL be a sub-module fetch_fifo (2 entries, push/pop/flush, count output).

Verification
REQ-029 Reset release, ready=1 -> rom_req at cycle 1 with addr RESET_VECTOR; instr_valid cycle 3, then pc +4 every cycle.
REQ-030 ready=0 for 10 cycles -> at most 2 requests outstanding, FIFO full, head stable; ready=1 -> entries drain in order, no loss.
REQ-031 bpu_pc_write with value 0x0000_0103 -> FIFO flushed, next rom_addr 0x0000_0100, instr_pc 0x100 three cycles after strobe.
REQ-032 ex_redirect target 0x200 and bpu_pc_write 0x300 same cycle -> next rom_addr 0x200, no 0x300 fetch.
REQ-033 Redirect in cycle where a response is in flight -> that response never appears on instr_data.
REQ-034 PC = 0xFFFF_FFFC fetching -> next rom_addr 0x0000_0000; rst_n pulsed mid-stream -> outputs match REQ-025 within the same cycle.
